pipelined_adder: RTL

Parametrised, pipelined add/subtract unit with a valid/ready stream handshake on both sides. A WIDTH-bit operation is split into STAGES equal chunks. Each chunk is added in its own pipeline stage, and the carry is registered between stages. This keeps the clock rate independent of WIDTH and gives one result per cycle at full throughput. It replaces the purely combinational adder in datapaths that need wide operands, subtraction, signed overflow or flow control.

---
 rtl/pipelined_adder.sv | 96 +++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: WIDTH split into STAGES carry chunks, one chunk resolved per stage.
// Latency STAGES edges, one beat/cycle; global stall while the result is held (in_ready = !out_valid || out_ready).
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int C = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] be_in;
    logic             ce_in;

    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] be_q    [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];

    // Subtraction is a + ~b + ~cin, so cout = 1 means no borrow.
    assign be_in = sub ? ~b : b;
    assign ce_in = sub ? ~cin : cin;

    assign out_valid = valid_q[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0] src_a;
            logic [WIDTH-1:0] src_be;
            logic [WIDTH-1:0] src_sum;
            logic [WIDTH-1:0] sum_d;
            logic             src_c;
            logic             src_v;
            logic [C:0]       part;

            if (k == 0) begin : g_head
                assign src_a   = a;
                assign src_be  = be_in;
                assign src_sum = '0;
                assign src_c   = ce_in;
                assign src_v   = in_valid;
            end else begin : g_body
                assign src_a   = a_q[k-1];
                assign src_be  = be_q[k-1];
                assign src_sum = sum_q[k-1];
                assign src_c   = carry_q[k-1];
                assign src_v   = valid_q[k-1];
            end

            assign part = {1'b0, src_a[k*C +: C]} + {1'b0, src_be[k*C +: C]} + {{C{1'b0}}, src_c};

            // Lower chunks ride along already finished; this stage fills in chunk k.
            always_comb begin
                sum_d            = src_sum;
                sum_d[k*C +: C]  = part[C-1:0];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q[k] <= 1'b0;
                    carry_q[k] <= 1'b0;
                    a_q[k]     <= '0;
                    be_q[k]    <= '0;
                    sum_q[k]   <= '0;
                end else if (advance) begin
                    valid_q[k] <= src_v;
                    carry_q[k] <= part[C];
                    a_q[k]     <= src_a;
                    be_q[k]    <= src_be;
                    sum_q[k]   <= sum_d;
                end
            end
        end
    endgenerate

    assign sum  = sum_q[STAGES-1];
    assign cout = carry_q[STAGES-1];
    assign ovf  = (a_q[STAGES-1][WIDTH-1] == be_q[STAGES-1][WIDTH-1]) &&
                  (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule
